mul4_fitness_scorer: RTL
========================

# mul4_fitness_scorer

Sequential fitness-evaluation stage directly downstream of an evolved `mul4` individual. Streams test vectors through the individual and checks each lane output against the golden 32x32 product, where `{a1,a0} * {b1,b0} = {y3,y2,y1,y0}`. Accumulates a match score over a fixed number of vectors and reports it once per evaluation run. Sits between the vector source and the tournament selection logic in the Verilator harness.

## Interface
- `NUM_VECTORS`, default 64: vectors per evaluation run, range 1..1024.
- `SCORE_W`, default 17: accumulator width. Must hold `NUM_VECTORS*64`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `start`  in  1: begins a run. Honoured only in IDLE.
- `in_valid`  in  1: vector and DUT outputs are present on the inputs.
- `in_ready`  out  1: scorer accepts a vector this cycle.
- `a1`, `a0`, `b1`, `b0`  in  16 each: operand limbs; index 1 is the high limb.
- `y3`, `y2`, `y1`, `y0`  in  16 each: DUT outputs; `y3` is the most significant limb.
- `score`  out  SCORE_W: accumulated score. Held between runs.
- `done`  out  1: one-cycle pulse when `score` becomes final.
- `busy`  out  1: high in RUN and DRAIN.

## Operation
- States:
  - IDLE: `in_ready`=0. If `start`, go to RUN and clear `score`, the vector counter and the pipeline.
  - RUN: `in_ready`=1. A vector is accepted on any edge with `in_valid & in_ready`, and the counter increments. The edge that accepts vector number `NUM_VECTORS` moves the state to DRAIN.
  - DRAIN: `in_ready`=0. Waits until both pipeline stages are empty, then goes to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored. `in_valid` gaps in RUN are legal; the counter holds during a gap.
- Golden value: `G = {a1,a0} * {b1,b0}`, full 64-bit unsigned, split into limbs G3..G0.
- Per-vector score (see Configuration):
  - Hamming mode: number of equal bits between `{y3..y0}` and G, range 0..64.
  - Lane mode: number of exactly matching 16-bit lanes, range 0..4.
- Accumulation is unsigned and saturates at `2^SCORE_W-1`. It never wraps.

## Timing
- Reset values: `score`=0, `done`=0, `in_ready`=0, `busy`=0, state=IDLE, both pipeline valid bits 0.
- Pipeline, for a vector accepted at edge E0:
  - E0: S1 registers the four 16x16 partial products and the y limbs.
  - E1: S2 sums the partial products, compares against y, and registers the per-vector score.
  - E2: the per-vector score is added to `score`.
- Last vector accepted at E0: DRAIN covers the cycles after E0. DONE is entered at E2 with the final `score`. `done` is high in the cycle after E2.
- Total latency from `start` sampled to `done` with no `in_valid` gaps: `NUM_VECTORS + 3` cycles.
- Reset asserted in any state takes effect at the next edge: state returns to IDLE, `score` clears, in-flight vectors are discarded, and no `done` pulse is emitted.

## Configuration
- `MUL4_SCORE_HAMMING_EN`:
  - Defined: Hamming mode, per-vector score 0..64.
  - Undefined: lane mode, per-vector score 0..4. The popcount logic is removed.
- The `SCORE_W` requirement scales with the mode, but the default of 17 suffices for both.

## Structure
- Package `mul4_pkg`:
  - constants `LANES`=4, `LANE_W`=16, `PROD_W`=64
  - state enum `{IDLE, RUN, DRAIN, DONE}`
  - per-vector score typedef `vec_score_t`, 7 bits
- Sub-module `mul4_golden_mul`: the two-stage pipelined 32x32 unsigned multiplier with a valid bit. It is reused by the vector-source checker.
- The top level contains the FSM, vector counter, compare/popcount logic and saturating accumulator.

## Test plan
- Correct product, Hamming mode, `NUM_VECTORS`=4: drive `{a1,a0}`=0x00000003, `{b1,b0}`=0x00000005, `{y3..y0}`=0x000000000000000F four times → `score`=256, with `done` 7 cycles after `start`.
- Wrong output, Hamming mode, `NUM_VECTORS`=1: same operands with y all zero (G has 4 set bits) → `score`=60.
- Lane mode, `NUM_VECTORS`=1: `{a1,a0}` = `{b1,b0}` = 0xFFFFFFFF, y = 0xFFFFFFFE00000000 (y0 wrong) → `score`=3.
- Backpressure and ignored start, `NUM_VECTORS`=4: `in_valid` toggles 1,0,1,0,… and `start` is pulsed during RUN → exactly 4 vectors are counted, the run is not restarted, and a single `done` pulse occurs.
- Mid-run reset: `rst_n`=0 for one cycle after 2 of 4 vectors are accepted → `score`=0, IDLE, `in_ready`=0, and no `done`. A following `start` runs cleanly.
- Saturation: `SCORE_W`=6, Hamming mode, `NUM_VECTORS`=2, all vectors correct → `score`=63, not 128 mod 64.

Source files
------------

// File: rtl/mul4_pkg.sv
// rtl/mul4_pkg.sv - shared constants, FSM state and per-vector scoring helpers for the mul4 fitness scorer
package mul4_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 16;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef logic [6:0] vec_score_t;

    function automatic vec_score_t popcount_prod(input logic [PROD_W-1:0] x);
        vec_score_t n;
        n = '0;
        for (int i = 0; i < PROD_W; i++) begin
            n = n + vec_score_t'(x[i]);
        end
        return n;
    endfunction

    function automatic vec_score_t lane_matches(input logic [PROD_W-1:0] y,
                                                input logic [PROD_W-1:0] g);
        vec_score_t n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            if (y[i*LANE_W +: LANE_W] == g[i*LANE_W +: LANE_W]) begin
                n = n + vec_score_t'(1);
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/mul4_golden_mul.sv
// rtl/mul4_golden_mul.sv - two-stage pipelined 32x32 unsigned golden multiplier with valid tracking
module mul4_golden_mul
    import mul4_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [LANE_W-1:0] i_a1,
    input  logic [LANE_W-1:0] i_a0,
    input  logic [LANE_W-1:0] i_b1,
    input  logic [LANE_W-1:0] i_b0,
    output logic              o_s1_valid,
    output logic              o_valid,
    output logic [PROD_W-1:0] o_prod
);

    logic [2*LANE_W-1:0] r_pp00, r_pp01, r_pp10, r_pp11;
    logic [PROD_W-1:0]   r_prod;
    logic                r_s1_valid, r_s2_valid;
    logic [PROD_W-1:0]   w_sum;

    // Cross terms land at bit 16; the sum cannot exceed 64 bits for unsigned 32x32.
    assign w_sum = {r_pp11, r_pp00}
                 + {16'b0, r_pp01, 16'b0}
                 + {16'b0, r_pp10, 16'b0};

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= i_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    always_ff @(posedge clk) begin
        r_pp00 <= 32'(i_a0) * 32'(i_b0);
        r_pp01 <= 32'(i_a0) * 32'(i_b1);
        r_pp10 <= 32'(i_a1) * 32'(i_b0);
        r_pp11 <= 32'(i_a1) * 32'(i_b1);
        r_prod <= w_sum;
    end

    assign o_s1_valid = r_s1_valid;
    assign o_valid    = r_s2_valid;
    assign o_prod     = r_prod;

endmodule

// File: rtl/mul4_fitness_scorer.sv
// rtl/mul4_fitness_scorer.sv - streams vectors through a mul4 individual and accumulates a saturating match score
// MUL4_SCORE_HAMMING_EN selects bitwise Hamming scoring; otherwise whole 16-bit lanes are scored.
module mul4_fitness_scorer
    import mul4_pkg::*;
#(
    parameter int NUM_VECTORS = 64,
    parameter int SCORE_W     = 17
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANE_W-1:0]  a1,
    input  logic [LANE_W-1:0]  a0,
    input  logic [LANE_W-1:0]  b1,
    input  logic [LANE_W-1:0]  b0,
    input  logic [LANE_W-1:0]  y3,
    input  logic [LANE_W-1:0]  y2,
    input  logic [LANE_W-1:0]  y1,
    input  logic [LANE_W-1:0]  y0,
    output logic [SCORE_W-1:0] score,
    output logic               done,
    output logic               busy
);

    localparam int CNT_W = $clog2(NUM_VECTORS + 1);
    localparam int SUM_W = ((SCORE_W > 7) ? SCORE_W : 7) + 1;
    localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [SCORE_W-1:0] r_score;
    logic [PROD_W-1:0]  r_y_s1, r_y_s2;

    logic               w_accept, w_last, w_start;
    logic               w_s1_valid, w_s2_valid;
    logic [PROD_W-1:0]  w_prod;
    vec_score_t         w_vec_score;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_score_nxt;

    assign w_start  = (r_state == IDLE) && start;
    assign w_accept = in_valid && in_ready;
    assign w_last   = w_accept && (r_cnt == CNT_W'(NUM_VECTORS - 1));

    mul4_golden_mul u_golden (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start),
        .i_valid    (w_accept),
        .i_a1       (a1),
        .i_a0       (a0),
        .i_b1       (b1),
        .i_b0       (b0),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_prod     (w_prod)
    );

    always_ff @(posedge clk) begin
        r_y_s1 <= {y3, y2, y1, y0};
        r_y_s2 <= r_y_s1;
    end

`ifdef MUL4_SCORE_HAMMING_EN
    assign w_vec_score = popcount_prod(~(r_y_s2 ^ w_prod));
`else
    assign w_vec_score = lane_matches(r_y_s2, w_prod);
`endif

    assign w_sum       = SUM_W'(r_score) + SUM_W'(w_vec_score);
    assign w_score_nxt = (w_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving DRAIN once S1 is empty lets S2 retire into score on the same edge DONE is entered.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DRAIN;
            DRAIN:   if (!w_s1_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == RUN);
        busy     = (r_state == RUN) || (r_state == DRAIN);
        done     = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_start) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_start) begin
            r_score <= '0;
        end else if (w_s2_valid) begin
            r_score <= w_score_nxt;
        end
    end

    assign score = r_score;

endmodule
